// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts issued-but-not-retired writes per register and flags RAW hazards to decode.
// Latency: hazard/stall outputs are combinational from current state; counts update on the rising edge.
// Backpressure: stall holds decode on a busy source or a saturated destination counter.
module reg_scoreboard #(
    parameter int ADDR_LEN = 4,
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2,
    parameter int OUT_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wb_en,
    input  logic [ADDR_LEN-1:0] issue_dest,
    input  logic [ADDR_LEN-1:0] src1,
    input  logic [ADDR_LEN-1:0] src2,
    input  logic                src1_used,
    input  logic                src2_used,
    input  logic                wb_en,
    input  logic [ADDR_LEN-1:0] wb_dest,
    input  logic                flush,
    output logic                stall,
    output logic                busy1,
    output logic                busy2,
    output logic [OUT_W-1:0]    outstanding,
    output logic                err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];

    logic [CNT_W-1:0] cnt_s1;
    logic [CNT_W-1:0] cnt_s2;
    logic [CNT_W-1:0] cnt_dst;
    logic [CNT_W-1:0] cnt_wb;
    logic             wb_live;
    logic             wb_dec;
    logic             underflow;
    logic             full_dest;
    logic             accept;

    assign cnt_s1  = cnt[src1];
    assign cnt_s2  = cnt[src2];
    assign cnt_dst = cnt[issue_dest];
    assign cnt_wb  = cnt[wb_dest];

    // A writeback that is not squashed by flush and not aimed at the zero register.
    assign wb_live   = wb_en && (wb_dest != '0) && !flush;
    assign wb_dec    = wb_live && (cnt_wb != CNT_ZERO);
    assign underflow = wb_live && (cnt_wb == CNT_ZERO);

    // The register file writes on the falling edge, so the last pending write retiring now is readable.
    assign busy1 = src1_used && (src1 != '0) && (cnt_s1 != CNT_ZERO)
                   && !(wb_live && (wb_dest == src1) && (cnt_s1 == CNT_ONE));
    assign busy2 = src2_used && (src2 != '0) && (cnt_s2 != CNT_ZERO)
                   && !(wb_live && (wb_dest == src2) && (cnt_s2 == CNT_ONE));

    assign full_dest = issue_wb_en && (issue_dest != '0) && (cnt_dst == CNT_MAX)
                       && !(wb_live && (wb_dest == issue_dest));

    assign stall  = issue_valid && (busy1 || busy2 || full_dest);
    assign accept = issue_valid && !stall && !flush && issue_wb_en && (issue_dest != '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = cnt[r];
            if (flush || r == 0) begin
                cnt_nxt[r] = CNT_ZERO;
            end else begin
                unique case ({accept && (issue_dest == ADDR_LEN'(r)),
                              wb_dec && (wb_dest == ADDR_LEN'(r))})
                    2'b10:   cnt_nxt[r] = cnt[r] + CNT_ONE;
                    2'b01:   cnt_nxt[r] = cnt[r] - CNT_ONE;
                    default: cnt_nxt[r] = cnt[r];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= CNT_ZERO;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else if (flush) begin
            outstanding <= '0;
        end else begin
            unique case ({accept, wb_dec})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky until reset; flush does not clear a protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (underflow) begin
            err <= 1'b1;
        end
    end

endmodule
